// File: rtl/id_stage_if.sv
// Bundles the IF/ID inputs, regfile read port and ID/EX register outputs of the decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface id_stage_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      if_valid;
  logic [WORD_WIDTH-1:0]     if_instr;
  logic [WORD_WIDTH-1:0]     if_pc;
  logic                      ex_flush;
  logic [WORD_WIDTH-1:0]     rd1;
  logic [WORD_WIDTH-1:0]     rd2;
  logic [REG_ADDR_WIDTH-1:0] ra1;
  logic [REG_ADDR_WIDTH-1:0] ra2;
  logic                      id_stall;
  logic                      idex_valid;
  logic                      idex_reg_write;
  logic                      idex_is_load;
  logic                      idex_is_store;
  logic                      idex_illegal;
  logic [WORD_WIDTH-1:0]     idex_pc;
  logic [WORD_WIDTH-1:0]     idex_rd1;
  logic [WORD_WIDTH-1:0]     idex_rd2;
  logic [WORD_WIDTH-1:0]     idex_imm;
  logic [REG_ADDR_WIDTH-1:0] idex_rs1;
  logic [REG_ADDR_WIDTH-1:0] idex_rs2;
  logic [REG_ADDR_WIDTH-1:0] idex_rd;
  logic [6:0]                idex_opcode;
  logic [2:0]                idex_funct3;
  logic                      idex_funct7b5;
  logic [CNT_WIDTH-1:0]      stall_cnt;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_flush, rd1, rd2,
    output ra1, ra2, id_stall,
    output idex_valid, idex_reg_write, idex_is_load, idex_is_store, idex_illegal,
    output idex_pc, idex_rd1, idex_rd2, idex_imm,
    output idex_rs1, idex_rs2, idex_rd, idex_opcode, idex_funct3, idex_funct7b5,
    output stall_cnt
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_flush, rd1, rd2,
    input  ra1, ra2, id_stall,
    input  idex_valid, idex_reg_write, idex_is_load, idex_is_store, idex_illegal,
    input  idex_pc, idex_rd1, idex_rd2, idex_imm,
    input  idex_rs1, idex_rs2, idex_rd, idex_opcode, idex_funct3, idex_funct7b5,
    input  stall_cnt
  );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: drives regfile reads, builds the immediate, detects
// load-use hazards, and registers the decoded instruction into the ID/EX register.
module id_stage #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input logic       clk,
  input logic       rst_n,
  id_stage_if.slave pipe
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic                      valid;
    logic                      regWrite;
    logic                      isLoad;
    logic                      isStore;
    logic                      illegal;
    logic [WORD_WIDTH-1:0]     pc;
    logic [WORD_WIDTH-1:0]     rd1;
    logic [WORD_WIDTH-1:0]     rd2;
    logic [WORD_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      funct7b5;
  } idex_t;

  logic [31:0]               instr;
  logic [REG_ADDR_WIDTH-1:0] rdField;
  logic                      usesRs1, usesRs2, writesRd, isLoad, isStore, illegal;
  logic [31:0]               imm32;
  logic                      hazard;
  idex_t                     idex_d, idex_q;
  logic [CNT_WIDTH-1:0]      stallCnt_d, stallCnt_q;

  assign instr     = pipe.if_instr[31:0];
  assign pipe.ra1  = pipe.if_instr[15 +: REG_ADDR_WIDTH];
  assign pipe.ra2  = pipe.if_instr[20 +: REG_ADDR_WIDTH];
  assign rdField   = pipe.if_instr[7 +: REG_ADDR_WIDTH];

  always_comb begin
    usesRs1  = 1'b0;
    usesRs2  = 1'b0;
    writesRd = 1'b0;
    isLoad   = 1'b0;
    isStore  = 1'b0;
    illegal  = 1'b0;
    imm32    = '0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        writesRd = 1'b1;
        imm32    = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        writesRd = 1'b1;
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR, OP_IMM: begin
        usesRs1  = 1'b1;
        writesRd = 1'b1;
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OP_BRANCH: begin
        usesRs1 = 1'b1;
        usesRs2 = 1'b1;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LOAD: begin
        usesRs1  = 1'b1;
        writesRd = 1'b1;
        isLoad   = 1'b1;
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        usesRs1 = 1'b1;
        usesRs2 = 1'b1;
        isStore = 1'b1;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_REG: begin
        usesRs1  = 1'b1;
        usesRs2  = 1'b1;
        writesRd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // The load still sits in ID/EX, so its data is not yet available to the consumer in ID.
  assign hazard = pipe.if_valid & idex_q.valid & idex_q.isLoad & (idex_q.rd != '0) &
                  ((usesRs1 & (pipe.ra1 == idex_q.rd)) | (usesRs2 & (pipe.ra2 == idex_q.rd)));

  assign pipe.id_stall = hazard & ~pipe.ex_flush;

  always_comb begin
    idex_d     = '0;
    stallCnt_d = stallCnt_q;
    if (!pipe.ex_flush && hazard) begin
      if (stallCnt_q != {CNT_WIDTH{1'b1}}) stallCnt_d = stallCnt_q + 1'b1;
    end else if (!pipe.ex_flush) begin
      idex_d.valid    = pipe.if_valid;
      idex_d.regWrite = pipe.if_valid & writesRd & (rdField != '0);
      idex_d.isLoad   = pipe.if_valid & isLoad;
      idex_d.isStore  = pipe.if_valid & isStore;
      idex_d.illegal  = pipe.if_valid & illegal;
      idex_d.pc       = pipe.if_pc;
      idex_d.rd1      = pipe.rd1;
      idex_d.rd2      = pipe.rd2;
      idex_d.imm      = WORD_WIDTH'($signed(imm32));
      idex_d.rs1      = pipe.ra1;
      idex_d.rs2      = pipe.ra2;
      idex_d.rd       = rdField;
      idex_d.opcode   = instr[6:0];
      idex_d.funct3   = instr[14:12];
      idex_d.funct7b5 = instr[30];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q     <= '0;
      stallCnt_q <= '0;
    end else begin
      idex_q     <= idex_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign pipe.idex_valid     = idex_q.valid;
  assign pipe.idex_reg_write = idex_q.regWrite;
  assign pipe.idex_is_load   = idex_q.isLoad;
  assign pipe.idex_is_store  = idex_q.isStore;
  assign pipe.idex_illegal   = idex_q.illegal;
  assign pipe.idex_pc        = idex_q.pc;
  assign pipe.idex_rd1       = idex_q.rd1;
  assign pipe.idex_rd2       = idex_q.rd2;
  assign pipe.idex_imm       = idex_q.imm;
  assign pipe.idex_rs1       = idex_q.rs1;
  assign pipe.idex_rs2       = idex_q.rs2;
  assign pipe.idex_rd        = idex_q.rd;
  assign pipe.idex_opcode    = idex_q.opcode;
  assign pipe.idex_funct3    = idex_q.funct3;
  assign pipe.idex_funct7b5  = idex_q.funct7b5;
  assign pipe.stall_cnt      = stallCnt_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline, directly upstream of the register file and downstream of fetch.
- Takes the IF/ID instruction, extracts register addresses and drives the regfile read ports.
- Generates the immediate, detects load-use hazards and flushes, and registers everything into the ID/EX pipeline register consumed by execute.
- WB-to-ID bypass is done inside the regfile; this block relies on it and does not repeat it.

Parameters:
- WORD_WIDTH, 32, datapath and instruction width.
- REG_ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_valid  in  1  IF/ID holds a real instruction.
- if_instr  in  WORD_WIDTH  IF/ID instruction.
- if_pc  in  WORD_WIDTH  IF/ID PC.
- ex_flush  in  1  branch/jump taken, resolved in EX this cycle.
- rd1, rd2  in  WORD_WIDTH  regfile read data.
- ra1, ra2  out  REG_ADDR_WIDTH  regfile read addresses.
- id_stall  out  1  fetch must hold PC and IF/ID this cycle.
- idex_valid, idex_reg_write, idex_is_load, idex_is_store, idex_illegal  out  1 each.
- idex_pc, idex_rd1, idex_rd2, idex_imm  out  WORD_WIDTH.
- idex_rs1, idex_rs2, idex_rd  out  REG_ADDR_WIDTH.
- idex_opcode  out  7.
- idex_funct3  out  3.
- idex_funct7b5  out  1.
- stall_cnt  out  CNT_WIDTH  saturating count of load-use stall cycles.

Behaviour:
- Register fields (combinational):
  - ra1 = if_instr[19:15], ra2 = if_instr[24:20], always, including when if_valid=0.
  - rd field = if_instr[11:7].
- Opcode class and immediate (sign-extended to WORD_WIDTH):
  - LUI 0110111 / AUIPC 0010111: U-type, imm = {instr[31:12],12'b0}, rd.
  - JAL 1101111: J-type, rd.
  - JALR 1100111: I-type, rs1, rd.
  - BRANCH 1100011: B-type, rs1, rs2, no rd.
  - LOAD 0000011: I-type, rs1, rd, is_load.
  - STORE 0100011: S-type, rs1, rs2, is_store.
  - OP-IMM 0010011: I-type, rs1, rd.
  - OP 0110011: R-type, imm=0, rs1, rs2, rd.
  - Any other opcode: illegal=1, reg_write=0, imm=0, no rs uses.
- reg_write = class writes rd AND rd != 0.
- Load-use hazard (combinational):
  - haz = if_valid & idex_valid & idex_is_load & idex_rd!=0 & ((uses_rs1 & ra1==idex_rd) | (uses_rs2 & ra2==idex_rd)).
  - Unused rs fields never cause a hazard.
- Stall and flush:
  - id_stall = haz & ~ex_flush.
  - Flush has priority over hazard; on flush the ID instruction is wrong-path and is dropped.
- ID/EX register update, each rising clk, evaluated in priority order:
  1. rst_n=0: all idex_* outputs 0, stall_cnt 0.
  2. ex_flush=1: bubble, i.e. idex_valid=0, idex_reg_write=0, idex_is_load=0, idex_is_store=0, idex_illegal=0. Other fields don't-care; they hold 0.
  3. haz=1: bubble as in step 2; stall_cnt increments, saturating at all-ones.
  4. Otherwise: capture the decoded instruction, rd1/rd2, and if_pc. idex_valid = if_valid; control flags are ANDed with if_valid.
- Latency: one cycle from IF/ID to ID/EX. A load-use pair costs exactly one bubble, since the next cycle the load is in MEM and haz clears.
- Reset mid-operation: a pending hazard or flush is discarded; the first post-reset cycle starts clean with idex_valid=0.
- id_stall is purely combinational from current inputs and ID/EX state; it is 0 while idex_valid=0, including during reset.
- stall_cnt counts only hazard-bubble cycles, not flush bubbles.

Test Plan:
- Reset: rst_n=0 for 2 cycles with if_valid=1 and an arbitrary instr -> all idex_* = 0, stall_cnt=0, id_stall=0.
- Immediates:
  - addi x1,x0,-1 (0xFFF00093) -> idex_imm=0xFFFFFFFF, idex_rd=1, reg_write=1.
  - sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, is_store=1, reg_write=0.
  - lui x3,0x12345 (0x123451B7) -> imm=0x12345000.
- Load-use: lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333):
  - Second cycle: id_stall=1, ra1=5.
  - Next edge: idex_valid=0 (bubble), stall_cnt=1.
  - Following edge: add captured, idex_rs1=5, idex_rd=6.
- No false hazard:
  - lw x5 then lui x5,0x1 -> no stall, since lui does not use rs1/rs2.
  - lw x0 followed by a use of x0 -> no stall.
- Flush vs hazard: same load-use pair with ex_flush=1 in the hazard cycle -> id_stall=0, bubble inserted, stall_cnt unchanged.
- Illegal opcode: instr 0xFFFFFFFF -> idex_valid=1, idex_illegal=1, reg_write=0, imm=0. With if_valid=0 -> idex_valid=0 and all control flags 0.
